iccm_loader: RTL and testbench

ICCM_LOADER -- requirements
Module: iccm_loader

---
 rtl/iccm_loader.sv | 190 +++++++++++++++++++
 tb/tb_iccm_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_loader.sv
// ---------------------------------------------------------------------------
// iccm_loader
//
// Purpose:
//   Receives a byte stream and writes it into the ICCM one 32-bit word at a
//   time. The stream starts with a 2-byte little-endian word count N. That
//   count is followed by 4*N payload bytes. Each payload word is little-endian,
//   so its first byte lands in wdata[7:0].
//   When the session ends, the loader raises a finish level so the core may
//   start fetching.
//
// Parameters:
//   ADDR_W     ICCM word-address width
//   DW         ICCM data width (the TL_DW of the top package, 32)
//   MAX_WORDS  ICCM capacity in words; a header larger than this is an error
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   start_i          single-cycle pulse that opens a load session
//   byte_valid_i     upstream byte valid
//   byte_data_i      upstream byte
//   byte_ready_o     loader takes the byte when valid and ready are both 1
//   tb2iccm_we_o     ICCM write strobe, one cycle per word
//   tb2mem_wdata_o   ICCM write data (holds its value between writes)
//   tb2mem_wmask_o   ICCM write mask (all ones during a write, else zero)
//   tb2mem_waddr_o   ICCM word address (holds its value between writes)
//   tb2mem_finish_o  load complete, held until reset or the next start
//   busy_o           session in progress
//   err_o            sticky header error
//   words_written_o  words written in the current session
// ---------------------------------------------------------------------------
module iccm_loader #(
  parameter int ADDR_W    = 11,
  parameter int DW        = 32,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              tb2iccm_we_o,
  output logic [DW-1:0]     tb2mem_wdata_o,
  output logic [DW-1:0]     tb2mem_wmask_o,
  output logic [ADDR_W-1:0] tb2mem_waddr_o,
  output logic              tb2mem_finish_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_written_o
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  // Extra MSB so that a 16-bit header can never alias onto the capacity limit
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_e              state_q;
  logic [15:0]         numWords_q;
  logic [1:0]          byteIdx_q;
  logic [23:0]         word_q;
  logic [ADDR_W:0]     wordCnt_q;
  logic                we_q;
  logic                finish_q;
  logic                busy_q;
  logic                err_q;
  logic [DW-1:0]       wdata_q;
  logic [DW-1:0]       wmask_q;
  logic [ADDR_W-1:0]   waddr_q;

  logic                xfer;
  logic [15:0]         hdrN;
  logic [ADDR_W:0]     wordCntInc;

  // The loader is ready only in the byte-consuming states. Bytes offered in any
  // other state stay with the upstream source.
  assign byte_ready_o = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
  assign xfer         = byte_valid_i && byte_ready_o;

  // Full word count as seen in the HDR_HI cycle, before it is registered.
  assign hdrN       = {byte_data_i, numWords_q[7:0]};
  assign wordCntInc = wordCnt_q + {{ADDR_W{1'b0}}, 1'b1};

  // Single FSM register block. Every output is registered, and each one is
  // updated on the same edge as the state transition that defines it.
  // The 4th payload byte bypasses word_q and goes straight into wdata.
  // That lets the strobe rise on the very next cycle. The strobe and the mask
  // default back to zero every cycle, so a write lasts exactly one cycle.
  // The mask also reads zero whenever no write is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      numWords_q <= '0;
      byteIdx_q  <= '0;
      word_q     <= '0;
      wordCnt_q  <= '0;
      we_q       <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      waddr_q    <= '0;
    end else begin
      we_q    <= 1'b0;
      wmask_q <= '0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q   <= HDR_LO;
            wordCnt_q <= '0;
            byteIdx_q <= '0;
            finish_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            numWords_q[7:0] <= byte_data_i;
            state_q         <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            numWords_q[15:8] <= byte_data_i;
            if (hdrN == 16'd0) begin
              state_q  <= DONE;
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
            end else if ({1'b0, hdrN} > MaxWords) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byteIdx_q <= byteIdx_q + 2'd1;
            if (byteIdx_q == 2'd3) begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              wmask_q <= '1;
              wdata_q <= DW'({byte_data_i, word_q});
              waddr_q <= wordCnt_q[ADDR_W-1:0];
            end else begin
              word_q[{byteIdx_q, 3'b000} +: 8] <= byte_data_i;
            end
          end
        end
        WRITE: begin
          wordCnt_q <= wordCntInc;
          if (16'(wordCntInc) == numWords_q) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tb2iccm_we_o    = we_q;
  assign tb2mem_wdata_o  = wdata_q;
  assign tb2mem_wmask_o  = wmask_q;
  assign tb2mem_waddr_o  = waddr_q;
  assign tb2mem_finish_o = finish_q;
  assign busy_o          = busy_q;
  assign err_o           = err_q;
  assign words_written_o = wordCnt_q;

endmodule

// File: tb/tb_iccm_loader.sv
// ---------------------------------------------------------------------------
// tb_iccm_loader
//
// Purpose:
//   Directed self-checking bench for iccm_loader. Inputs change and outputs
//   are sampled on falling clock edges. A monitor captures every write strobe
//   along with its cycle number, and each scenario then compares the captured
//   writes against hand-computed words.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_iccm_loader;

  localparam int ADDR_W    = 11;
  localparam int DW        = 32;
  localparam int MAX_WORDS = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byteValid;
  logic [7:0]        byteData;
  logic              byteReady;
  logic              we;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     wmask;
  logic [ADDR_W-1:0] waddr;
  logic              finish;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   wordsWritten;

  int vectors     = 0;
  int miscompares = 0;

  // Write capture filled by the monitor
  int                weCount  = 0;
  int                cycle    = 0;
  int                maskErrs = 0;
  logic [ADDR_W-1:0] capAddr  [4096];
  logic [31:0]       capData  [4096];
  logic [31:0]       capMask  [4096];
  int                capCycle [4096];

  iccm_loader #(
    .ADDR_W   (ADDR_W),
    .DW       (DW),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .byte_valid_i   (byteValid),
    .byte_data_i    (byteData),
    .byte_ready_o   (byteReady),
    .tb2iccm_we_o   (we),
    .tb2mem_wdata_o (wdata),
    .tb2mem_wmask_o (wmask),
    .tb2mem_waddr_o (waddr),
    .tb2mem_finish_o(finish),
    .busy_o         (busy),
    .err_o          (err),
    .words_written_o(wordsWritten)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to measure the spacing between write strobes
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor that records every write and flags a nonzero mask outside a write
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (weCount < 4096) begin
        capAddr[weCount]  = waddr;
        capData[weCount]  = wdata;
        capMask[weCount]  = wmask;
        capCycle[weCount] = cycle;
      end
      weCount = weCount + 1;
    end else if (wmask !== '0) begin
      maskErrs = maskErrs + 1;
    end
  end

  // Overall time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every vector and reports miscompares
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one byte and returns at the falling edge after it was consumed
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard     = 0;
    byteValid = 1'b1;
    byteData  = b;
    while (byteReady !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    byteValid = 1'b0;
  endtask

  // Pulses start for one clock cycle
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Applies reset for two clock cycles
  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Checks every output against its reset value
  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_ready"},  32'(byteReady),    32'd0);
    checkOutput({pfx, "_we"},     32'(we),           32'd0);
    checkOutput({pfx, "_finish"}, 32'(finish),       32'd0);
    checkOutput({pfx, "_busy"},   32'(busy),         32'd0);
    checkOutput({pfx, "_err"},    32'(err),          32'd0);
    checkOutput({pfx, "_wdata"},  wdata,             32'd0);
    checkOutput({pfx, "_wmask"},  wmask,             32'd0);
    checkOutput({pfx, "_waddr"},  32'(waddr),        32'd0);
    checkOutput({pfx, "_words"},  32'(wordsWritten), 32'd0);
  endtask

  // Payload word used by the full-capacity load
  function automatic logic [31:0] expWord(input int i);
    return {8'(i ^ 32'h5A), 8'(i >> 3), 8'(i + 1), 8'(i)};
  endfunction

  initial begin
    int base;
    int addrErrs;
    int dataErrs;
    int gapErrs;
    logic [31:0] w;

    rst       = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteData  = 8'h00;
    @(negedge clk);
    doReset();
    checkAllZero("reset");

    // Two-word load: 02 00 | 78 56 34 12 | EF BE AD DE
    base = weCount;
    pulseStart();
    checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
    checkOutput("t1_ready_hdr", 32'(byteReady), 32'd1);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    applyStimulus(8'h34);
    applyStimulus(8'h12);
    checkOutput("t1_we0", 32'(we), 32'd1);
    checkOutput("t1_ready_in_write", 32'(byteReady), 32'd0);
    applyStimulus(8'hEF);
    applyStimulus(8'hBE);
    applyStimulus(8'hAD);
    applyStimulus(8'hDE);
    checkOutput("t1_we1", 32'(we), 32'd1);
    @(negedge clk);
    checkOutput("t1_write_count", 32'(weCount - base), 32'd2);
    checkOutput("t1_addr0", 32'(capAddr[base]), 32'd0);
    checkOutput("t1_data0", capData[base], 32'h12345678);
    checkOutput("t1_mask0", capMask[base], 32'hFFFFFFFF);
    checkOutput("t1_addr1", 32'(capAddr[base+1]), 32'd1);
    checkOutput("t1_data1", capData[base+1], 32'hDEADBEEF);
    checkOutput("t1_mask1", capMask[base+1], 32'hFFFFFFFF);
    checkOutput("t1_latency", 32'(capCycle[base+1] - capCycle[base]), 32'd5);
    checkOutput("t1_finish", 32'(finish), 32'd1);
    checkOutput("t1_words", 32'(wordsWritten), 32'd2);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);
    checkOutput("t1_wdata_hold", wdata, 32'hDEADBEEF);
    checkOutput("t1_waddr_hold", 32'(waddr), 32'd1);
    checkOutput("t1_wmask_idle", wmask, 32'd0);

    // Empty load: header 00 00 goes straight to DONE
    base = weCount;
    pulseStart();
    checkOutput("t2_finish_cleared", 32'(finish), 32'd0);
    checkOutput("t2_words_cleared", 32'(wordsWritten), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("t2_finish", 32'(finish), 32'd1);
    checkOutput("t2_busy", 32'(busy), 32'd0);
    checkOutput("t2_ready", 32'(byteReady), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t2_no_writes", 32'(weCount - base), 32'd0);

    // Oversized header: 01 08 is N=2049
    base = weCount;
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h08);
    checkOutput("t3_err", 32'(err), 32'd1);
    checkOutput("t3_finish", 32'(finish), 32'd0);
    checkOutput("t3_ready", 32'(byteReady), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    byteValid = 1'b1;
    byteData  = 8'h5A;
    repeat (3) @(negedge clk);
    checkOutput("t3_ready_held_low", 32'(byteReady), 32'd0);
    checkOutput("t3_err_sticky", 32'(err), 32'd1);
    byteValid = 1'b0;
    checkOutput("t3_no_writes", 32'(weCount - base), 32'd0);
    pulseStart();
    checkOutput("t3_err_cleared", 32'(err), 32'd0);
    checkOutput("t3_busy_restart", 32'(busy), 32'd1);
    doReset();

    // Reset in the middle of a word, with gaps in the valid signal
    base = weCount;
    pulseStart();
    applyStimulus(8'h01);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    applyStimulus(8'h00);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    applyStimulus(8'hA1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    applyStimulus(8'hA2);
    byteValid = 1'b1;
    byteData  = 8'hA3;
    rst       = 1'b1;
    @(negedge clk);
    checkAllZero("t4_reset");
    rst       = 1'b0;
    repeat (8) @(negedge clk);
    byteValid = 1'b0;
    checkOutput("t4_no_writes", 32'(weCount - base), 32'd0);
    checkOutput("t4_idle_ready", 32'(byteReady), 32'd0);

    // Start pulses during DATA and WRITE are ignored; three words
    base = weCount;
    pulseStart();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    pulseStart();
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    pulseStart();
    applyStimulus(8'h99);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    @(negedge clk);
    checkOutput("t5_write_count", 32'(weCount - base), 32'd3);
    checkOutput("t5_data0", capData[base], 32'h44332211);
    checkOutput("t5_data1", capData[base+1], 32'h88776655);
    checkOutput("t5_addr2", 32'(capAddr[base+2]), 32'd2);
    checkOutput("t5_data2", capData[base+2], 32'hCCBBAA99);
    checkOutput("t5_finish", 32'(finish), 32'd1);
    checkOutput("t5_words", 32'(wordsWritten), 32'd3);

    // Full-capacity load: N=2048 with continuous valid
    base = weCount;
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h08);
    for (int i = 0; i < MAX_WORDS; i++) begin
      w = expWord(i);
      for (int j = 0; j < 4; j++) applyStimulus(w[8*j +: 8]);
    end
    @(negedge clk);
    checkOutput("t6_write_count", 32'(weCount - base), 32'd2048);
    addrErrs = 0;
    dataErrs = 0;
    gapErrs  = 0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (32'(capAddr[base+k]) !== 32'(k)) addrErrs++;
      if (capData[base+k] !== expWord(k) || capMask[base+k] !== 32'hFFFFFFFF) dataErrs++;
      if (k > 0 && (capCycle[base+k] - capCycle[base+k-1]) != 5) gapErrs++;
    end
    checkOutput("t6_addr_errs", 32'(addrErrs), 32'd0);
    checkOutput("t6_data_errs", 32'(dataErrs), 32'd0);
    checkOutput("t6_gap_errs", 32'(gapErrs), 32'd0);
    checkOutput("t6_last_addr", 32'(capAddr[base+MAX_WORDS-1]), 32'd2047);
    checkOutput("t6_finish", 32'(finish), 32'd1);
    checkOutput("t6_words", 32'(wordsWritten), 32'd2048);
    checkOutput("t6_err", 32'(err), 32'd0);

    checkOutput("mask_outside_write", 32'(maskErrs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
